// File: rtl/sipo_word_receiver.sv
// Serial-in/parallel-out word receiver: LSB-first reassembly, frame alignment,
// single-word valid/ready output register and sticky overrun flag.
module sipo_word_receiver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serial_in,
  input  logic                     bit_valid,
  input  logic                     frame_start,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  input  logic                     clear_overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  assign shifted = {serial_in, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    complete = 1'b0;
    if (frame_start) begin
      // Frame alignment overrides completion: the incoming bit (if any) opens a new word.
      if (bit_valid) begin
        shreg_d = shifted;
        cnt_d   = CW'(1);
        state_d = COLLECT;
      end else begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    end else if (bit_valid) begin
      shreg_d = shifted;
      case (state_q)
        IDLE: begin
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
        COLLECT: begin
          if (cnt_q == LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pout_d  = pout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clear_overrun) ovr_d = 1'b0;
    if (complete) begin
      if (!valid_q || out_ready) begin
        pout_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = pout_q;
  assign out_valid    = valid_q;
  assign overrun      = ovr_q;
  assign bit_count    = cnt_q;

endmodule
